color_ram_gen: RTL and testbench

Parametrised dual-port colour/palette RAM, successor to the fixed 16x4 colour RAM.
- Port A: CPU read/write port.
- Port B: video read port with read enable, optional write-forwarding and an optional output pipeline stage.
- Built-in clear engine initialises every entry after reset, so no simulation-only init is needed and hardware power-up state is deterministic.
- Sits between the CPU bus decode and the video palette lookup.

---
 rtl/color_ram_gen_if.sv | 30 +++
 rtl/color_ram_gen.sv | 118 +++++++++++
 tb/tb_color_ram_gen.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/color_ram_gen_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// color_ram_gen_if: CPU (A) and video (B) port bundle for color_ram_gen
// rev 1.0
// ----------------------------------------------------------------------------
interface color_ram_gen_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] din_a;
  logic              we_n_a;
  logic [DATA_W-1:0] dout_a;
  logic [ADDR_W-1:0] addr_b;
  logic              re_b;
  logic [DATA_W-1:0] dout_b;
  logic              valid_b;
  logic              busy;

  modport master (
    output addr_a, din_a, we_n_a, addr_b, re_b,
    input  dout_a, dout_b, valid_b, busy
  );

  modport slave (
    input  addr_a, din_a, we_n_a, addr_b, re_b,
    output dout_a, dout_b, valid_b, busy
  );
endinterface
`default_nettype wire

// File: rtl/color_ram_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// color_ram_gen: dual-port palette RAM with a post-reset clear engine
// rev 1.0
// ----------------------------------------------------------------------------
module color_ram_gen #(
  parameter int                DATA_W         = 4,
  parameter int                ADDR_W         = 4,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0,
  parameter bit                BYPASS_B       = 1'b1,
  parameter bit                OUT_REG_B      = 1'b0
) (
  input  logic           clk_a,
  input  logic           reset,
  color_ram_gen_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] clr_ptr;
  logic              clr_we;
  logic              busy;
  logic              wr_a;
  logic              collide;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] dout_a_q;
  logic [DATA_W-1:0] stage_d;
  logic              stage_v;

  always_ff @(posedge clk_a) begin
    if (reset) begin
      if (CLEAR_ON_RESET) state <= ST_CLEAR;
      else                state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    clr_we   = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (clr_ptr == {ADDR_W{1'b1}}) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // busy is the state register itself, so it drops the cycle after the last clear write
  assign busy    = (state == ST_CLEAR);
  assign wr_a    = ~busy & ~bus.we_n_a;
  assign collide = BYPASS_B & ~bus.we_n_a & (bus.addr_a == bus.addr_b);

  always_ff @(posedge clk_a) begin
    if (reset)       clr_ptr <= '0;
    else if (clr_we) clr_ptr <= clr_ptr + 1'b1;
  end

  always_ff @(posedge clk_a) begin
    if (!reset) begin
      if (clr_we)    mem[clr_ptr]    <= CLEAR_VALUE;
      else if (wr_a) mem[bus.addr_a] <= bus.din_a;
    end
  end

  always_ff @(posedge clk_a) begin
    if (reset) begin
      dout_a_q <= '0;
      stage_d  <= '0;
      stage_v  <= 1'b0;
    end else begin
      stage_v <= bus.re_b;
      if (busy) begin
        dout_a_q <= CLEAR_VALUE;
        stage_d  <= CLEAR_VALUE;
      end else begin
        dout_a_q <= mem[bus.addr_a];
        if (bus.re_b) stage_d <= collide ? bus.din_a : mem[bus.addr_b];
      end
    end
  end

  assign bus.dout_a = dout_a_q;
  assign bus.busy   = busy;

  generate
    if (OUT_REG_B) begin : g_out_reg
      logic [DATA_W-1:0] out_d;
      logic              out_v;

      always_ff @(posedge clk_a) begin
        if (reset) begin
          out_d <= '0;
          out_v <= 1'b0;
        end else begin
          out_d <= stage_d;
          out_v <= stage_v;
        end
      end

      assign bus.dout_b  = out_d;
      assign bus.valid_b = out_v;
    end else begin : g_out_direct
      assign bus.dout_b  = stage_d;
      assign bus.valid_b = stage_v;
    end
  endgenerate
endmodule
`default_nettype wire

// File: tb/tb_color_ram_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_color_ram_gen: scoreboard bench for two color_ram_gen configurations
// rev 1.0
// ----------------------------------------------------------------------------
module tb_color_ram_gen;
  localparam int         D1   = 16;
  localparam logic [3:0] CV1  = 4'h0;
  localparam int         D2   = 64;
  localparam logic [7:0] CV2  = 8'h3C;

  typedef struct {
    logic [7:0] a;
    logic       busy;
    logic [7:0] hold;
  } exp_a_t;

  typedef struct {
    logic [7:0] d;
    int         due;
  } exp_b_t;

  logic clk = 1'b0;
  logic rst1;
  logic rst2;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  color_ram_gen_if #(.DATA_W(4), .ADDR_W(4)) b1 ();
  color_ram_gen_if #(.DATA_W(8), .ADDR_W(6)) b2 ();

  color_ram_gen dut1 (.clk_a(clk), .reset(rst1), .bus(b1));

  color_ram_gen #(
    .DATA_W(8), .ADDR_W(6), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV2),
    .BYPASS_B(1'b0), .OUT_REG_B(1'b1)
  ) dut2 (.clk_a(clk), .reset(rst2), .bus(b2));

  // reference state: plain arrays, a clear countdown and the last value port B latched
  logic [3:0] m1 [D1];
  logic [7:0] m2 [D2];
  int         clr1 = 0;
  int         clr2 = 0;
  logic [3:0] hold1 = 4'h0;
  exp_a_t     qa1[$];
  exp_a_t     qa2[$];
  exp_b_t     qb1[$];
  exp_b_t     qb2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step1(input logic r, input logic [3:0] aa, input logic [3:0] da,
                       input logic wn, input logic [3:0] ab, input logic re);
    exp_a_t e;
    exp_b_t eb;
    logic   bz;
    @(negedge clk);
    rst1 = r; b1.addr_a = aa; b1.din_a = da; b1.we_n_a = wn; b1.addr_b = ab; b1.re_b = re;
    bz = (clr1 > 0);
    if (r) begin
      e.a = 8'h0; e.busy = 1'b1; hold1 = 4'h0; clr1 = D1;
      foreach (m1[i]) m1[i] = CV1;
    end else begin
      e.a = bz ? {4'h0, CV1} : {4'h0, m1[aa]};
      if (bz)      hold1 = CV1;
      else if (re) hold1 = (!wn && aa == ab) ? da : m1[ab];
      if (re) begin
        eb.d = {4'h0, hold1}; eb.due = cyc + 1; qb1.push_back(eb);
      end
      if (!bz && !wn) m1[aa] = da;
      if (clr1 > 0) clr1--;
      e.busy = (clr1 > 0);
    end
    e.hold = {4'h0, hold1};
    qa1.push_back(e);
  endtask

  task automatic step2(input logic r, input logic [5:0] aa, input logic [7:0] da,
                       input logic wn, input logic [5:0] ab, input logic re);
    exp_a_t e;
    exp_b_t eb;
    logic   bz;
    @(negedge clk);
    rst2 = r; b2.addr_a = aa; b2.din_a = da; b2.we_n_a = wn; b2.addr_b = ab; b2.re_b = re;
    bz = (clr2 > 0);
    if (r) begin
      e.a = 8'h0; e.busy = 1'b1; clr2 = D2;
      foreach (m2[i]) m2[i] = CV2;
    end else begin
      e.a = bz ? CV2 : m2[aa];
      if (re) begin
        eb.d = bz ? CV2 : m2[ab]; eb.due = cyc + 2; qb2.push_back(eb);
      end
      if (!bz && !wn) m2[aa] = da;
      if (clr2 > 0) clr2--;
      e.busy = (clr2 > 0);
    end
    e.hold = 8'h0;
    qa2.push_back(e);
  endtask

  initial begin : mon1
    exp_a_t e;
    exp_b_t eb;
    forever begin
      @(posedge clk); #1;
      if (qa1.size() != 0) begin
        e = qa1.pop_front();
        chk("a1_dout_a", b1.dout_a, e.a);
        chk("a1_busy", b1.busy, e.busy);
        if (b1.valid_b === 1'b1) begin
          if (qb1.size() == 0) chk("b1_spurious_valid", b1.valid_b, 0);
          else begin
            eb = qb1.pop_front();
            chk("b1_dout_b", b1.dout_b, eb.d);
            chk("b1_latency", cyc, eb.due);
          end
        end else begin
          chk("b1_hold", b1.dout_b, e.hold);
          if (qb1.size() != 0 && qb1[0].due <= cyc) chk("b1_missing_valid", b1.valid_b, 1);
        end
      end
    end
  end

  initial begin : mon2
    exp_a_t e;
    exp_b_t eb;
    forever begin
      @(posedge clk); #1;
      if (qa2.size() != 0) begin
        e = qa2.pop_front();
        chk("a2_dout_a", b2.dout_a, e.a);
        chk("a2_busy", b2.busy, e.busy);
        if (b2.valid_b === 1'b1) begin
          if (qb2.size() == 0) chk("b2_spurious_valid", b2.valid_b, 0);
          else begin
            eb = qb2.pop_front();
            chk("b2_dout_b", b2.dout_b, eb.d);
            chk("b2_latency", cyc, eb.due);
          end
        end else if (qb2.size() != 0 && qb2[0].due <= cyc) begin
          chk("b2_missing_valid", b2.valid_b, 1);
        end
      end
    end
  end

  initial begin
    rst1 = 1'b1; rst2 = 1'b1;
    b1.addr_a = '0; b1.din_a = '0; b1.we_n_a = 1'b1; b1.addr_b = '0; b1.re_b = 1'b0;
    b2.addr_a = '0; b2.din_a = '0; b2.we_n_a = 1'b1; b2.addr_b = '0; b2.re_b = 1'b0;

    // clear sequence, then a reset landing on clear pointer 7
    repeat (3) step1(1'b1, 4'($urandom), 4'($urandom), 1'b0, 4'($urandom), 1'($urandom));
    repeat (7) step1(1'b0, 4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
    step1(1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i == 4) step1(1'b0, 4'd3, 4'h5, 1'b0, 4'd3, 1'b1);
      else step1(1'b0, 4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
    end
    for (int i = 0; i < D1; i++) step1(1'b0, 4'(i), 4'h0, 1'b1, 4'(15 - i), 1'b1);

    // port A write, read, read-before-write
    step1(1'b0, 4'd5, 4'h9, 1'b0, 4'd0, 1'b0);
    step1(1'b0, 4'd5, 4'h0, 1'b1, 4'd0, 1'b0);
    step1(1'b0, 4'd5, 4'h3, 1'b0, 4'd0, 1'b0);
    step1(1'b0, 4'd5, 4'h0, 1'b1, 4'd0, 1'b0);
    step1(1'b0, 4'd5, 4'h9, 1'b0, 4'd0, 1'b0);

    // port B collision with write forwarding
    step1(1'b0, 4'd2, 4'h1, 1'b0, 4'd0, 1'b0);
    step1(1'b0, 4'd2, 4'hC, 1'b0, 4'd2, 1'b1);
    step1(1'b0, 4'd2, 4'h0, 1'b1, 4'd2, 1'b1);

    // port B hold while re_b is low
    step1(1'b0, 4'd0, 4'h0, 1'b1, 4'd5, 1'b1);
    for (int k = 0; k < 4; k++) step1(1'b0, 4'd0, 4'h0, 1'b1, 4'(k + 7), 1'b0);

    for (int i = 0; i < 300; i++) begin
      logic [3:0] aa;
      aa = 4'($urandom);
      step1(1'b0, aa, 4'($urandom), ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1,
            ($urandom_range(0, 3) == 0) ? aa : 4'($urandom), 1'($urandom));
    end
    repeat (3) step1(1'b0, 4'd0, 4'd0, 1'b1, 4'd0, 1'b0);

    // wide, pipelined, non-forwarding configuration
    repeat (2) step2(1'b1, 6'd0, 8'h0, 1'b1, 6'd0, 1'b0);
    for (int i = 0; i < D2; i++)
      step2(1'b0, 6'd3, 8'h55, (i == 10) ? 1'b0 : 1'b1, 6'(i), (i % 9) == 0);
    step2(1'b0, 6'd63, 8'hA5, 1'b0, 6'd0, 1'b0);
    step2(1'b0, 6'd0, 8'h00, 1'b1, 6'd63, 1'b1);
    repeat (2) step2(1'b0, 6'd0, 8'h00, 1'b1, 6'd0, 1'b0);
    step2(1'b0, 6'd2, 8'h11, 1'b0, 6'd0, 1'b0);
    step2(1'b0, 6'd2, 8'hCC, 1'b0, 6'd2, 1'b1);
    step2(1'b0, 6'd3, 8'h00, 1'b1, 6'd2, 1'b1);
    for (int i = 0; i < 150; i++) begin
      logic [5:0] aa;
      aa = 6'($urandom_range(0, 7));
      step2(1'b0, aa, 8'($urandom), ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1,
            ($urandom_range(0, 3) == 0) ? aa : 6'($urandom_range(0, 7)), 1'($urandom));
    end
    repeat (4) step2(1'b0, 6'd0, 8'h0, 1'b1, 6'd0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    chk("b1_drain", qb1.size(), 0);
    chk("b2_drain", qb2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
